codec_sample_sequencer: RTL
===========================

# codec_sample_sequencer

- Per-sample controller between the audio CODEC's ready/strobe interface and a stereo processing engine (e.g. FIR filter).
- Sequence per sample:
  - Wait for a sample from the CODEC.
  - Acknowledge it with a one-cycle `read` strobe and hand both channels to the engine over a valid/ready handshake.
  - Capture the engine result and push it to the CODEC with a one-cycle `write` strobe when the DAC side is ready.
- Sits in the top level in place of the direct read-to-write loopback.
- Supports a raw-audio bypass and an optional engine watchdog.

## Interface
Parameters:
- `DW`, 24, sample width per channel (signed).
- `TIMEOUT`, 1023, engine watchdog limit in clock cycles (watchdog builds only).

Ports:
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `read_ready`  in  1  CODEC has an ADC sample pair available.
- `write_ready`  in  1  CODEC can accept a DAC sample pair.
- `readdata_left`, `readdata_right`  in  DW  ADC samples.
- `read`  out  1  one-cycle acknowledge to the CODEC.
- `write`  out  1  one-cycle write strobe to the CODEC.
- `writedata_left`, `writedata_right`  out  DW  DAC samples, registered.
- `proc_valid`  out  1  `proc_in_*` holds a sample pair for the engine.
- `proc_ready`  in  1  engine accepts the pair.
- `proc_in_left`, `proc_in_right`  out  DW  samples to the engine.
- `proc_out_valid`  in  1  engine result valid (single-cycle or held).
- `proc_out_left`, `proc_out_right`  in  DW  engine result.
- `bypass`  in  1  route raw samples to the DAC, skipping the engine.
- `busy`  out  1  high in any state other than IDLE.
- `sample_count`  out  16  number of completed `write` strobes; wraps modulo 2^16.
- `timeout_flag`  out  1  sticky; an engine timeout has occurred.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE:
  - `read_ready` is sampled only in this state.
  - When `read_ready`=1: latch `readdata_*` into `proc_in_*`, assert `read` for exactly the next cycle.
  - Next state is WRITE if `bypass`=1, else ISSUE.
  - In the bypass case, also load `writedata_*` with the raw samples.
- ISSUE:
  - `proc_valid`=1; `proc_in_*` held stable.
  - On `proc_valid & proc_ready`, drop `proc_valid` and go to WAIT.
- WAIT:
  - On `proc_out_valid`, latch `proc_out_*` into `writedata_*` and go to WRITE.
  - A `proc_out_valid` seen in any other state is ignored.
- WRITE:
  - On `write_ready`=1, assert `write` for exactly the next cycle, increment `sample_count`, return to IDLE.
- `bypass` is sampled only at the IDLE→ISSUE/WRITE decision. Changing it mid-sample has no effect until the next sample.
- No arithmetic on samples. Data passes bit-exact at width DW.
- `read` and `write` are never high in two consecutive cycles.
- `read` and `write` are never high in the same cycle.
- Reset (`resetn`=0 at a clock edge, any state, including mid-handshake):
  - Next state IDLE.
  - All outputs 0: `read`, `write`, `proc_valid`, `busy`, `writedata_*`, `proc_in_*`, `sample_count`, `timeout_flag`.
  - The in-flight sample is discarded. No `write` is issued for it.

## Timing
- All outputs are registered. No combinational input→output paths.
- `read_ready`=1 in IDLE at edge N → `read`=1 during cycle N+1, `busy`=1 from N+1.
- Bypass, `write_ready` already 1: `write`=1 at cycle N+2. This is the minimum sample latency.
- Engine path, `proc_ready`=1 immediately and result after L cycles: `proc_valid` high cycle N+1, WAIT from N+2, `write` strobe no earlier than N+4+L.
- `writedata_*` is valid from entry to WRITE and stays stable until the next capture. It is therefore stable during the `write` cycle.
- `sample_count` updates in the same cycle `write` rises.

## Configuration
- Macro `CODEC_SEQ_WATCHDOG_EN`.
- Defined:
  - A cycle counter runs in ISSUE and WAIT, cleared on entry to ISSUE.
  - When it reaches `TIMEOUT` without leaving WAIT: load `writedata_*` with the raw latched `proc_in_*`, set `timeout_flag` (sticky until reset), deassert `proc_valid`, go to WRITE.
  - A `proc_out_valid` arriving in the same cycle as expiry wins: the result is used and the flag is not set.
- Undefined:
  - No counter is built and `TIMEOUT` is unused.
  - ISSUE/WAIT wait indefinitely.
  - `timeout_flag` is tied to 0.

## Test plan
- **Bypass loop**: `bypass`=1, `readdata`=L 24'h123456 / R 24'hFEDCBA, `write_ready`=1 → `read` pulse at N+1, `write` pulse at N+2 with identical data, `sample_count`=1.
- **Engine path**: engine returns input+1 after 5 cycles, `proc_ready` delayed 3 cycles → `proc_in_*` stable throughout ISSUE, `writedata` = input+1, exactly one `read` and one `write` per sample.
- **DAC backpressure**: `write_ready` held 0 for 100 cycles in WRITE with `read_ready`=1 → no second `read` and `writedata` unchanged. Releasing `write_ready` gives one `write`, then the next sample is read.
- **Watchdog** (macro defined, `TIMEOUT`=16): engine never returns → `write` carries the raw samples ~17 cycles after ISSUE and `timeout_flag`=1. A second, normal sample keeps the flag at 1.
- **Reset mid-WAIT**: `resetn`=0 for one cycle → all outputs 0 next cycle and no `write` for the discarded sample. A following sample completes normally with `sample_count`=1.
- **Counter wrap**: 65536 bypass samples → `sample_count` returns to 0.

Source files
------------

// File: rtl/codec_sample_sequencer.sv
// -----------------------------------------------------------------------------
// codec_sample_sequencer
//
// Per-sample controller between the audio CODEC ready/strobe interface and a
// stereo processing engine. Each ADC sample pair is acknowledged with a
// one-cycle `read` strobe and handed to the engine over valid/ready. The
// engine result is pushed to the DAC with a one-cycle `write` strobe once the
// CODEC is ready. A bypass input routes the raw samples straight to the DAC.
//
// Optional build macro:
//   CODEC_SEQ_WATCHDOG_EN - engine watchdog; after TIMEOUT cycles in
//                           ISSUE/WAIT the raw samples are written instead and
//                           timeout_flag is set (sticky until reset).
//
// Ports:
//   CLOCK_50, resetn                  clock, synchronous active-low reset
//   read_ready, write_ready           CODEC ADC-available / DAC-accept
//   readdata_left/right               ADC samples
//   read, write                       one-cycle CODEC strobes (registered)
//   writedata_left/right              DAC samples (registered)
//   proc_valid, proc_ready            engine input handshake
//   proc_in_left/right                samples to the engine (registered)
//   proc_out_valid, proc_out_left/right  engine result
//   bypass                            skip the engine for the next sample
//   busy                              not in IDLE
//   sample_count                      completed writes, wraps at 2^16
//   timeout_flag                      sticky engine timeout indicator
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for read_ready; latches the ADC pair on arrival
// S_ISSUE | proc_valid high, waiting for the engine to accept
// S_WAIT  | waiting for proc_out_valid
// S_WRITE | writedata valid, waiting for write_ready
// -----------------------------------------------------------------------------
module codec_sample_sequencer #(
    parameter int DW      = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          read_ready,
    input  logic          write_ready,
    input  logic [DW-1:0] readdata_left,
    input  logic [DW-1:0] readdata_right,
    output logic          read,
    output logic          write,
    output logic [DW-1:0] writedata_left,
    output logic [DW-1:0] writedata_right,
    output logic          proc_valid,
    input  logic          proc_ready,
    output logic [DW-1:0] proc_in_left,
    output logic [DW-1:0] proc_in_right,
    input  logic          proc_out_valid,
    input  logic [DW-1:0] proc_out_left,
    input  logic [DW-1:0] proc_out_right,
    input  logic          bypass,
    output logic          busy,
    output logic [15:0]   sample_count,
    output logic          timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic accept;      // sample taken from the CODEC this cycle
    logic capture;     // engine result taken this cycle
    logic expire;      // watchdog gave up on the engine this cycle
    logic fire_write;  // DAC write issued this cycle
    logic wd_done;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        fire_write = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_ready) begin
                    accept    = 1'b1;
                    state_nxt = bypass ? S_WRITE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Expiry takes precedence over a late acceptance: the sample
                // is abandoned and any later engine result lands outside WAIT.
                if (wd_done) begin
                    expire    = 1'b1;
                    state_nxt = S_WRITE;
                end else if (proc_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still wins.
                if (proc_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_WRITE;
                end else if (wd_done) begin
                    expire    = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (write_ready) begin
                    fire_write = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        proc_valid = (state == S_ISSUE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            read            <= 1'b0;
            write           <= 1'b0;
            proc_in_left    <= '0;
            proc_in_right   <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            sample_count    <= '0;
        end else begin
            read  <= accept;
            write <= fire_write;
            if (accept) begin
                proc_in_left  <= readdata_left;
                proc_in_right <= readdata_right;
            end
            if (accept && bypass) begin
                writedata_left  <= readdata_left;
                writedata_right <= readdata_right;
            end else if (capture) begin
                writedata_left  <= proc_out_left;
                writedata_right <= proc_out_right;
            end else if (expire) begin
                writedata_left  <= proc_in_left;
                writedata_right <= proc_in_right;
            end
            if (fire_write) begin
                sample_count <= sample_count + 16'd1;
            end
        end
    end

`ifdef CODEC_SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] wd_cnt;

    // Down-counter loaded on entry to ISSUE; terminal count zero is expiry.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (accept && !bypass) begin
                wd_cnt <= WD_W'(TIMEOUT);
            end else if ((state == S_ISSUE || state == S_WAIT) && !wd_done) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign wd_done = (wd_cnt == '0);
`else
    assign wd_done      = 1'b0;
    assign timeout_flag = 1'b0;

    // TIMEOUT only shapes the watchdog build; nothing is generated here.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

endmodule
